// File: rtl/man_module_seg_pkg.sv
// Shared types and helpers for the segmented HD-vector manipulator.
// Request fields are kept at a fixed 32-bit width; unused upper bits are constant zero.
package man_module_seg_pkg;

  localparam int MEM_ROW_WIDTH = 256;
  localparam int MAN_W         = 32;

  typedef enum logic [1:0] {
    MAN_IDLE = 2'd0,
    MAN_BUSY = 2'd1,
    MAN_DONE = 2'd2
  } man_state_e;

  typedef struct packed {
    logic             en;
    logic [MAN_W-1:0] value;
    logic [MAN_W-1:0] key;
  } man_req_t;

  // Number of bits to flip: value * SPREAD (cannot overflow for legal configurations).
  function automatic logic [MAN_W-1:0] man_threshold(input logic [MAN_W-1:0] value,
                                                     input int unsigned spread);
    return value * MAN_W'(spread);
  endfunction

endpackage

// File: rtl/man_module_seg_mask.sv
// Combinational flip-mask generator for one SEG_WIDTH slice of the hypervector.
// A bit is set when its key-scrambled global index falls below the threshold.
module man_seg_mask
  import man_module_seg_pkg::*;
#(
  parameter int SEG_WIDTH = 256,
  parameter int SEG_IDX_W = 1
) (
  input  logic [SEG_IDX_W-1:0] seg_idx_i,
  input  logic [MAN_W-1:0]     key_i,
  input  logic [MAN_W-1:0]     thr_i,
  output logic [SEG_WIDTH-1:0] mask_o
);

  logic [MAN_W-1:0] base_s;

  assign base_s = MAN_W'(seg_idx_i) * MAN_W'(SEG_WIDTH);

  // Per-bit compare of the scrambled global index against the threshold
  always_comb begin
    mask_o = '0;
    for (int i = 0; i < SEG_WIDTH; i++) begin
      mask_o[i] = (((base_s + MAN_W'(i)) ^ key_i) < thr_i);
    end
  end

endmodule

// File: rtl/man_module_seg.sv
// Sequential HD-vector manipulator: flips value*SPREAD key-selected bits,
// processing SEG_WIDTH bits per cycle with valid/ready on both sides.
module man_module_seg
  import man_module_seg_pkg::*;
#(
  parameter  int VALUE_WIDTH = 7,
  parameter  int VEC_WIDTH   = MEM_ROW_WIDTH,
  parameter  int SEG_WIDTH   = 256,
  localparam int KEY_WIDTH   = $clog2(VEC_WIDTH),
  localparam int SPREAD      = VEC_WIDTH / (2 ** (VALUE_WIDTH + 1)),
  localparam int NUM_SEG     = VEC_WIDTH / SEG_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic                   en_i,
  input  logic [VALUE_WIDTH-1:0] value_i,
  input  logic [KEY_WIDTH-1:0]   key_i,
  input  logic [VEC_WIDTH-1:0]   vector_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [VEC_WIDTH-1:0]   vector_o,
  output logic [VEC_WIDTH-1:0]   mask_o
);

  localparam int SEG_CNT_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;

  if ((VEC_WIDTH & (VEC_WIDTH - 1)) != 0) begin : g_err_pow2
    $error("VEC_WIDTH must be a power of two");
  end
  if ((SEG_WIDTH <= 0) || ((VEC_WIDTH % SEG_WIDTH) != 0)) begin : g_err_seg
    $error("SEG_WIDTH must divide VEC_WIDTH");
  end
  if (SPREAD < 1) begin : g_err_spread
    $error("SPREAD must be at least 1");
  end
  if ((KEY_WIDTH > MAN_W) || (VALUE_WIDTH > MAN_W)) begin : g_err_width
    $error("VALUE_WIDTH/KEY_WIDTH exceed the request field width");
  end

  man_state_e             state_q;
  logic [SEG_CNT_W-1:0]   seg_cnt_q;
  logic                   en_q;
  logic [MAN_W-1:0]       thr_q;
  logic [MAN_W-1:0]       key_q;
  logic [VEC_WIDTH-1:0]   vec_q, vec_d;
  logic [VEC_WIDTH-1:0]   mask_q, mask_d;
  logic                   out_valid_q;
  man_req_t               req_s;
  logic [MAN_W-1:0]       thr_eff_s;
  logic [SEG_WIDTH-1:0]   seg_mask_s;
  logic                   in_ready_s;
  logic                   accept_s;
  logic                   last_seg_s;

  assign req_s      = '{en: en_i, value: MAN_W'(value_i), key: MAN_W'(key_i)};
  assign thr_eff_s  = en_q ? thr_q : {MAN_W{1'b0}};
  assign last_seg_s = (seg_cnt_q == SEG_CNT_W'(NUM_SEG - 1));
  assign accept_s   = in_valid_i & in_ready_s;

  // DONE forwards out_ready so a new request can be taken in the handshake cycle
  always_comb begin
    if (rst_i) begin
      in_ready_s = 1'b0;
    end else begin
      case (state_q)
        MAN_IDLE: in_ready_s = 1'b1;
        MAN_DONE: in_ready_s = out_ready_i;
        default:  in_ready_s = 1'b0;
      endcase
    end
  end

  man_seg_mask #(
    .SEG_WIDTH (SEG_WIDTH),
    .SEG_IDX_W (SEG_CNT_W)
  ) u_seg_mask (
    .seg_idx_i (seg_cnt_q),
    .key_i     (key_q),
    .thr_i     (thr_eff_s),
    .mask_o    (seg_mask_s)
  );

  // Segment write-back mux: only the slice selected by seg_cnt is updated
  always_comb begin
    vec_d  = vec_q;
    mask_d = mask_q;
    for (int s = 0; s < NUM_SEG; s++) begin
      if (seg_cnt_q == SEG_CNT_W'(s)) begin
        vec_d[s*SEG_WIDTH +: SEG_WIDTH]  = vec_q[s*SEG_WIDTH +: SEG_WIDTH] ^ seg_mask_s;
        mask_d[s*SEG_WIDTH +: SEG_WIDTH] = seg_mask_s;
      end else begin
        vec_d[s*SEG_WIDTH +: SEG_WIDTH]  = vec_q[s*SEG_WIDTH +: SEG_WIDTH];
        mask_d[s*SEG_WIDTH +: SEG_WIDTH] = mask_q[s*SEG_WIDTH +: SEG_WIDTH];
      end
    end
  end

  // Control FSM with working registers doubling as the output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= MAN_IDLE;
      seg_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      en_q        <= 1'b0;
      thr_q       <= '0;
      key_q       <= '0;
      vec_q       <= '0;
      mask_q      <= '0;
    end else begin
      case (state_q)
        MAN_IDLE: begin
          if (accept_s) begin
            en_q      <= req_s.en;
            thr_q     <= man_threshold(req_s.value, SPREAD);
            key_q     <= req_s.key;
            vec_q     <= vector_i;
            seg_cnt_q <= '0;
            state_q   <= MAN_BUSY;
          end else begin
            state_q   <= MAN_IDLE;
          end
        end
        MAN_BUSY: begin
          vec_q  <= vec_d;
          mask_q <= mask_d;
          if (last_seg_s) begin
            seg_cnt_q   <= '0;
            out_valid_q <= 1'b1;
            state_q     <= MAN_DONE;
          end else begin
            seg_cnt_q   <= seg_cnt_q + SEG_CNT_W'(1);
          end
        end
        MAN_DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            if (accept_s) begin
              en_q      <= req_s.en;
              thr_q     <= man_threshold(req_s.value, SPREAD);
              key_q     <= req_s.key;
              vec_q     <= vector_i;
              seg_cnt_q <= '0;
              state_q   <= MAN_BUSY;
            end else begin
              state_q   <= MAN_IDLE;
            end
          end else begin
            state_q <= MAN_DONE;
          end
        end
        default: begin
          state_q     <= MAN_IDLE;
          seg_cnt_q   <= '0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_s;
  assign out_valid_o = out_valid_q;
  assign vector_o    = vec_q;
  assign mask_o      = mask_q;

endmodule

// File: tb/tb_man_module_seg.sv
// Self-checking bench for man_module_seg: directed vector table, stall and
// reset sequences, and a randomized stalled stream against a reference model.
module tb_man_module_seg;

  localparam int VW     = 3;
  localparam int VEC    = 256;
  localparam int SEG    = 64;
  localparam int KW     = 8;
  localparam int SPREAD = 16;
  localparam int NSEG   = 4;
  localparam int LAT    = NSEG + 1;
  localparam int NRAND  = 1000;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic           en;
  logic [VW-1:0]  value;
  logic [KW-1:0]  key;
  logic [VEC-1:0] vector;
  logic           out_valid;
  logic           out_ready;
  logic [VEC-1:0] vector_o;
  logic [VEC-1:0] mask_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  man_module_seg #(
    .VALUE_WIDTH (VW),
    .VEC_WIDTH   (VEC),
    .SEG_WIDTH   (SEG)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .en_i        (en),
    .value_i     (value),
    .key_i       (key),
    .vector_i    (vector),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .vector_o    (vector_o),
    .mask_o      (mask_o)
  );

  typedef struct {
    logic           en;
    logic [VW-1:0]  value;
    logic [KW-1:0]  key;
    logic [VEC-1:0] vec;
    logic [VEC-1:0] exp_mask;
    logic [VEC-1:0] exp_vec;
  } tv_t;

  typedef struct {
    logic [VEC-1:0] m;
    logic [VEC-1:0] v;
  } exp_t;

  task automatic chk(input string name, input logic [VEC-1:0] got, input logic [VEC-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Reference: the flipped set is the image of {0..T-1} under q -> q ^ key.
  function automatic logic [VEC-1:0] ref_mask(input logic e, input int v, input int k);
    logic [VEC-1:0] m;
    int t;
    m = '0;
    t = e ? v * SPREAD : 0;
    for (int q = 0; q < t; q++) m[q ^ k] = 1'b1;
    return m;
  endfunction

  function automatic logic [VEC-1:0] rnd_vec();
    logic [VEC-1:0] r;
    for (int i = 0; i < VEC / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One request from IDLE with out_ready high; returns outputs and latency.
  task automatic do_txn(input logic e, input logic [VW-1:0] v, input logic [KW-1:0] k,
                        input logic [VEC-1:0] vin, output logic [VEC-1:0] m,
                        output logic [VEC-1:0] vo, output int lat);
    @(negedge clk);
    en = e; value = v; key = k; vector = vin;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    m = mask_o;
    vo = vector_o;
    @(posedge clk);
  endtask

  initial begin
    tv_t            tv[6];
    logic [VEC-1:0] rv0, rv1, rv2, m, vo, sv, sm, bvec, cvec;
    logic [VEC-1:0] ones, top32;
    int             lat;
    exp_t           q[$];
    exp_t           ex;
    int             sent, recv, cyc;
    bit             have, prev_hold;
    logic [VEC-1:0] prev_v, prev_m;

    ones  = {VEC{1'b1}};
    top32 = {32'hFFFF_FFFF, 224'h0};
    rv0 = rnd_vec(); rv1 = rnd_vec(); rv2 = rnd_vec();
    tv[0] = '{1'b1, 3'd1, 8'h00, 256'h0, 256'hFFFF, 256'hFFFF};
    tv[1] = '{1'b1, 3'd7, 8'hA5, ones, ref_mask(1'b1, 7, 'hA5), ~ref_mask(1'b1, 7, 'hA5)};
    tv[2] = '{1'b1, 3'd2, 8'hFF, rv0, top32, rv0 ^ top32};
    tv[3] = '{1'b0, 3'd5, 8'h3C, rv1, 256'h0, rv1};
    tv[4] = '{1'b1, 3'd0, 8'h77, rv2, 256'h0, rv2};
    tv[5] = '{1'b1, 3'd1, 8'h10, 256'h0, 256'hFFFF_0000, 256'hFFFF_0000};

    rst = 1'b1; in_valid = 1'b0; en = 1'b0; value = '0; key = '0; vector = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_int("rst_out_valid", int'(out_valid), 0);
    chk_int("rst_in_ready", int'(in_ready), 0);
    chk("rst_vector", vector_o, 256'h0);
    chk("rst_mask", mask_o, 256'h0);
    rst = 1'b0;
    #1;
    chk_int("post_rst_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 6; i++) begin
      do_txn(tv[i].en, tv[i].value, tv[i].key, tv[i].vec, m, vo, lat);
      chk_int($sformatf("tv%0d_latency", i), lat, LAT);
      chk($sformatf("tv%0d_mask", i), m, tv[i].exp_mask);
      chk($sformatf("tv%0d_vector", i), vo, tv[i].exp_vec);
      if (i == 1) chk_int("tv1_popcount", $countones(m), 112);
    end

    // Output stall with a new request waiting, then back-to-back accept
    bvec = rnd_vec();
    @(negedge clk);
    en = 1'b1; value = 3'd3; key = 8'h42; vector = rnd_vec();
    sv = vector;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    en = 1'b1; value = 3'd6; key = 8'h9E; vector = bvec;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk_int("stall_a_latency", lat, LAT);
    chk("stall_a_mask", mask_o, ref_mask(1'b1, 3, 'h42));
    chk("stall_a_vector", vector_o, sv ^ ref_mask(1'b1, 3, 'h42));
    sm = mask_o; sv = vector_o;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_int("stall_out_valid", int'(out_valid), 1);
      chk_int("stall_in_ready", int'(in_ready), 0);
      chk("stall_vector_hold", vector_o, sv);
      chk("stall_mask_hold", mask_o, sm);
    end
    out_ready = 1'b1;
    #1;
    chk_int("done_in_ready_follows", int'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk_int("b2b_latency", lat, LAT);
    chk("b2b_mask", mask_o, ref_mask(1'b1, 6, 'h9E));
    chk("b2b_vector", vector_o, bvec ^ ref_mask(1'b1, 6, 'h9E));
    @(posedge clk);

    // Reset pulse while the third segment is being processed
    cvec = rnd_vec();
    @(negedge clk);
    en = 1'b1; value = 3'd7; key = 8'h01; vector = cvec;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_int("midrst_out_valid", int'(out_valid), 0);
    chk_int("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_vector", vector_o, 256'h0);
    chk("midrst_mask", mask_o, 256'h0);
    rst = 1'b0;
    #1;
    chk_int("midrst_in_ready_after", int'(in_ready), 1);
    do_txn(1'b1, 3'd5, 8'hC3, cvec, m, vo, lat);
    chk_int("after_rst_latency", lat, LAT);
    chk("after_rst_mask", m, ref_mask(1'b1, 5, 'hC3));
    chk("after_rst_vector", vo, cvec ^ ref_mask(1'b1, 5, 'hC3));

    // Randomized stream with stalls on both sides
    sent = 0; recv = 0; cyc = 0; have = 1'b0; prev_hold = 1'b0;
    prev_v = '0; prev_m = '0;
    while (recv < NRAND && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (prev_hold) begin
        chk_int("rand_valid_hold", int'(out_valid), 1);
        chk("rand_vector_hold", vector_o, prev_v);
        chk("rand_mask_hold", mask_o, prev_m);
      end
      if (!have && sent < NRAND && $urandom_range(3) != 0) begin
        have = 1'b1;
        en = ($urandom_range(7) != 0);
        value = VW'($urandom_range(7));
        key = KW'($urandom_range(255));
        vector = rnd_vec();
      end
      in_valid = have;
      out_ready = ($urandom_range(3) != 0);
      #1;
      if (in_valid && in_ready) begin
        ex.m = ref_mask(en, int'(value), int'(key));
        ex.v = vector ^ ex.m;
        q.push_back(ex);
        have = 1'b0;
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rand_unexpected_output got=result exp=none");
        end else begin
          ex = q.pop_front();
          chk("rand_mask", mask_o, ex.m);
          chk("rand_vector", vector_o, ex.v);
        end
        recv++;
      end
      prev_hold = out_valid && !out_ready;
      prev_v = vector_o;
      prev_m = mask_o;
    end
    in_valid = 1'b0;
    chk_int("rand_sent", sent, NRAND);
    chk_int("rand_received", recv, NRAND);
    chk_int("rand_pending", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
